// File: rtl/channel_receiver.sv
// Receive endpoint of the inter-core channel: filters packets by destination, buffers payload
// flits in a show-ahead FIFO for the local core and returns credits to the sender.
module channel_receiver #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CORE   = 2,
  parameter int unsigned MY_ID      = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ch_valid,
  input  logic                  ch_head,
  input  logic [DATA_WIDTH-1:0] ch_data,
  output logic [1:0]            ch_credit,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [7:0]            pkt_cnt,
  output logic [7:0]            drop_cnt,
  output logic                  ovf_err,
  output logic                  proto_err
);

  localparam int unsigned IdW   = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  typedef enum logic [1:0] {StIdle, StBody, StDrop} state_e;

  state_e state_q, state_d;
  logic [3:0] rem_q, rem_d;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [AddrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  logic [1:0] credit_q, credit_d;
  logic [7:0] pkt_cnt_q, drop_cnt_q;
  logic       ovf_q, proto_q;

  logic [IdW-1:0] dest;
  logic [3:0]     len;
  logic           mine;
  logic           fifo_wr, wr_last, pkt_inc, drop_inc, proto_set;
  logic           full, pop, wr_ok, ovf_set;

  assign dest = ch_data[DATA_WIDTH-1 -: IdW];
  assign len  = ch_data[3:0];
  assign mine = (dest == IdW'(MY_ID));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // A header always restarts framing, whatever state it lands in.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    fifo_wr   = 1'b0;
    wr_last   = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    proto_set = 1'b0;
    if (ch_valid) begin
      if (ch_head) begin
        proto_set = (state_q != StIdle);
        if (mine) begin
          if (len == 4'd0) begin
            pkt_inc = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StBody;
            rem_d   = len;
          end
        end else begin
          drop_inc = 1'b1;
          if (len == 4'd0) begin
            state_d = StIdle;
          end else begin
            state_d = StDrop;
            rem_d   = len;
          end
        end
      end else begin
        case (state_q)
          StBody: begin
            fifo_wr = 1'b1;
            wr_last = (rem_q == 4'd1);
            rem_d   = rem_q - 4'd1;
            if (rem_q == 4'd1) begin
              state_d = StIdle;
              pkt_inc = 1'b1;
            end
          end
          StDrop: begin
            rem_d = rem_q - 4'd1;
            if (rem_q == 4'd1) state_d = StIdle;
          end
          default: proto_set = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    out_valid = (count_q != '0);
    out_data  = out_valid ? mem_data[rd_ptr_q] : '0;
    out_last  = out_valid & mem_last[rd_ptr_q];
  end

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign pop     = out_valid & out_ready;
  assign wr_ok   = fifo_wr & (~full | pop);
  assign ovf_set = fifo_wr & full & ~pop;
  // Every accepted flit that does not occupy a FIFO slot hands its credit straight back.
  assign credit_d = {1'b0, ch_valid & ~wr_ok} + {1'b0, pop};

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_data[wr_ptr_q] <= ch_data;
      mem_last[wr_ptr_q] <= wr_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (wr_ok && !pop) count_q <= count_q + CntW'(1);
      else if (!wr_ok && pop) count_q <= count_q - CntW'(1);
      credit_q <= credit_d;
      if (pkt_inc) pkt_cnt_q <= pkt_cnt_q + 8'd1;
      if (drop_inc && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      if (ovf_set) ovf_q <= 1'b1;
      if (proto_set) proto_q <= 1'b1;
    end
  end

  assign ch_credit = credit_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign ovf_err   = ovf_q;
  assign proto_err = proto_q;

endmodule

// File: tb/tb_channel_receiver.sv
// Bench for channel_receiver: directed scenarios plus random traffic, checked every cycle
// against a packet-level reference model.
module tb_channel_receiver;

  localparam int DW    = 8;
  localparam int IDW   = 1;
  localparam int DEPTH = 4;

  logic          clk, rst;
  logic          ch_valid, ch_head;
  logic [DW-1:0] ch_data;
  logic [1:0]    ch_credit;
  logic          out_valid, out_last, out_ready;
  logic [DW-1:0] out_data;
  logic [7:0]    pkt_cnt, drop_cnt;
  logic          ovf_err, proto_err;

  channel_receiver #(
    .DATA_WIDTH(DW),
    .NUM_CORE  (2),
    .MY_ID     (0),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_valid (ch_valid),
    .ch_head  (ch_head),
    .ch_data  (ch_data),
    .ch_credit(ch_credit),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt),
    .ovf_err  (ovf_err),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: packet progress and the list of flits waiting for the core.
  logic [DW:0] mq[$];
  bit          m_inpkt, m_keep;
  int          m_rem;
  logic [7:0]  m_pkt, m_drop;
  logic        m_ovf, m_proto;
  logic [1:0]  m_credit;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_inpkt = 0; m_keep = 0; m_rem = 0;
    m_pkt = 0; m_drop = 0; m_ovf = 0; m_proto = 0; m_credit = 0;
  endtask

  task automatic model_edge(input logic v, input logic h, input logic [DW-1:0] d,
                            input logic rdy);
    bit          pop, stored;
    logic [DW:0] wr;
    int          len;
    pop    = (mq.size() > 0) && rdy;
    stored = 0;
    wr     = '0;
    if (v) begin
      if (h) begin
        if (m_inpkt) m_proto = 1;
        m_inpkt = 0;
        len = int'(d[3:0]);
        if (d[DW-1 -: IDW] == 0) begin
          if (len == 0) m_pkt = m_pkt + 8'd1;
          else begin m_inpkt = 1; m_keep = 1; m_rem = len; end
        end else begin
          if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
          if (len > 0) begin m_inpkt = 1; m_keep = 0; m_rem = len; end
        end
      end else if (!m_inpkt) begin
        m_proto = 1;
      end else begin
        if (m_keep) begin
          wr = {(m_rem == 1), d};
          if (mq.size() < DEPTH || pop) stored = 1;
          else m_ovf = 1;
        end
        m_rem--;
        if (m_rem == 0) begin
          m_inpkt = 0;
          if (m_keep) m_pkt = m_pkt + 8'd1;
        end
      end
    end
    if (pop) void'(mq.pop_front());
    if (stored) mq.push_back(wr);
    m_credit = 2'(int'(v && !stored) + int'(pop));
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_data", 32'(out_data), 32'(mq[0][DW-1:0]));
      chk("out_last", 32'(out_last), 32'(mq[0][DW]));
    end
    chk("ch_credit", 32'(ch_credit), 32'(m_credit));
    chk("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    chk("proto_err", 32'(proto_err), 32'(m_proto));
  endtask

  task automatic check_zero();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_credit", 32'(ch_credit), 32'd0);
    chk("rst_pkt", 32'(pkt_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_proto", 32'(proto_err), 32'd0);
  endtask

  task automatic cyc(input logic v, input logic h, input logic [DW-1:0] d, input logic rdy);
    ch_valid  = v;
    ch_head   = h;
    ch_data   = d;
    out_ready = rdy;
    @(posedge clk);
    model_edge(v, h, d, rdy);
    #1;
    check_all();
  endtask

  function automatic logic [DW-1:0] hdr(input logic dest, input logic [3:0] len);
    return {dest, 3'b000, len};
  endfunction

  initial begin
    logic [DW-1:0] rd;
    logic          rv, rh, rr;
    rst = 1'b0; ch_valid = 0; ch_head = 0; ch_data = '0; out_ready = 0;
    model_reset();
    #12;
    check_zero();
    rst = 1'b1;

    // Own packet, L=3, consumed immediately
    cyc(1, 1, hdr(0, 3), 1);
    cyc(1, 0, 8'h11, 1);
    cyc(1, 0, 8'h22, 1);
    cyc(1, 0, 8'h33, 1);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);

    // Foreign packet
    cyc(1, 1, hdr(1, 2), 1);
    cyc(1, 0, 8'hAA, 1);
    cyc(1, 0, 8'hBB, 1);
    cyc(0, 0, 8'h00, 1);

    // Backpressure: fill the FIFO, then drain
    cyc(1, 1, hdr(0, 4), 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'h40 + i), 0);
    cyc(0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 1);

    // Overflow: fifth payload hits a full FIFO
    cyc(1, 1, hdr(0, 5), 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h50 + i), 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 1);

    // Stray payload in idle
    cyc(1, 0, 8'h55, 1);
    cyc(0, 0, 8'h00, 1);

    // New header interrupts a packet with two flits still owed
    cyc(1, 1, hdr(0, 3), 1);
    cyc(1, 0, 8'h61, 1);
    cyc(1, 1, hdr(0, 2), 1);
    cyc(1, 0, 8'h71, 1);
    cyc(1, 0, 8'h72, 1);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);

    // Asynchronous reset mid-packet with two flits buffered
    cyc(1, 1, hdr(0, 4), 0);
    cyc(1, 0, 8'h81, 0);
    cyc(1, 0, 8'h82, 0);
    ch_valid = 0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_zero();
    #1;
    rst = 1'b1;
    cyc(1, 1, hdr(0, 2), 1);
    cyc(1, 0, 8'h91, 1);
    cyc(1, 0, 8'h92, 1);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);

    // Random traffic, including full-with-pop and overflow cases
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rh = ($urandom_range(0, 4) == 0);
      rr = ($urandom_range(0, 2) != 0);
      rd = 8'($urandom);
      if (rh) rd[3:0] = 4'($urandom_range(0, 6));
      cyc(rv, rh, rd, rr);
    end
    for (int i = 0; i < 6; i++) cyc(0, 0, 8'h00, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
